// File: rtl/banco_registros.sv
// RISC-V integer register file: 31 writable registers, hardwired-zero x0, two combinational read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data onto matching read ports.
module banco_registros #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic [7:0]            wr_count
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
  logic [7:0]            wr_count_q;
  logic [7:0]            wr_count_d;
  logic                  commit_s;

  // A write commits only when enabled and not aimed at x0; clear priority is applied in the flops.
  always_comb begin
    commit_s = we && (rd_addr != {ADDR_WIDTH{1'b0}});
  end

  // Saturating count of committed writes.
  always_comb begin
    if (wr_count_q != 8'hFF) begin
      wr_count_d = wr_count_q + 8'd1;
    end else begin
      wr_count_d = wr_count_q;
    end
  end

  // Register storage and write counter; clear wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= {DATA_WIDTH{1'b0}};
      end
      wr_count_q <= 8'd0;
    end else if (commit_s) begin
      regs_q[rd_addr] <= wd;
      wr_count_q      <= wr_count_d;
    end else begin
      wr_count_q <= wr_count_q;
    end
  end

  // Read port 1: x0 reads zero; optional forwarding of the in-flight write-back.
  always_comb begin
    rs1_data = {DATA_WIDTH{1'b0}};
    if (rs1_addr == {ADDR_WIDTH{1'b0}}) begin
      rs1_data = {DATA_WIDTH{1'b0}};
`ifdef REGFILE_BYPASS_EN
    end else if (commit_s && !clear && (rs1_addr == rd_addr)) begin
      rs1_data = wd;
`endif
    end else begin
      rs1_data = regs_q[rs1_addr];
    end
  end

  // Read port 2: identical behaviour to port 1.
  always_comb begin
    rs2_data = {DATA_WIDTH{1'b0}};
    if (rs2_addr == {ADDR_WIDTH{1'b0}}) begin
      rs2_data = {DATA_WIDTH{1'b0}};
`ifdef REGFILE_BYPASS_EN
    end else if (commit_s && !clear && (rs2_addr == rd_addr)) begin
      rs2_data = wd;
`endif
    end else begin
      rs2_data = regs_q[rs2_addr];
    end
  end

  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_banco_registros.sv
// Scoreboard bench for banco_registros: driver pushes expected reads from a reference model, monitor compares.
module tb_banco_registros;

  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  rd_addr = 5'd0;
  logic [31:0] wd = 32'd0;
  logic [4:0]  rs1_addr = 5'd0;
  logic [4:0]  rs2_addr = 5'd0;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [7:0]  wr_count;

  banco_registros dut (
    .clk(clk), .clear(clear), .we(we), .rd_addr(rd_addr), .wd(wd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
    logic [7:0]  ec;
    string       tag;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passes = 0;
  bit driver_done = 1'b0;

  // Reference model: architectural register contents and committed-write count.
  logic [31:0] model_regs [32];
  int          model_cnt = 0;

  function automatic logic [31:0] model_read(input logic [4:0] a, input bit clr, input bit w,
                                             input logic [4:0] rd, input logic [31:0] d);
    if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (w && !clr && rd == a) return d;
`endif
    return model_regs[a];
  endfunction

  task automatic cycle(input bit clr, input bit w, input logic [4:0] rd, input logic [31:0] d,
                       input logic [4:0] a1, input logic [4:0] a2, input bit chk, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    clear = clr; we = w; rd_addr = rd; wd = d; rs1_addr = a1; rs2_addr = a2;
    if (chk) begin
      e.e1  = model_read(a1, clr, w, rd, d);
      e.e2  = model_read(a2, clr, w, rd, d);
      e.ec  = model_cnt[7:0];
      e.tag = tag;
      q.push_back(e);
    end
    if (clr) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
      model_cnt = 0;
    end else if (w && rd != 5'd0) begin
      model_regs[rd] = d;
      model_cnt = (model_cnt + 1 > 255) ? 255 : model_cnt + 1;
    end
  endtask

  // Monitor: outputs are settled by the falling edge; pop and compare one expectation per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (rs1_data === e.e1) passes++;
        else $display("FAIL %s rs1: got %h expected %h", e.tag, rs1_data, e.e1);
        checks++;
        if (rs2_data === e.e2) passes++;
        else $display("FAIL %s rs2: got %h expected %h", e.tag, rs2_data, e.e2);
        checks++;
        if (wr_count === e.ec) passes++;
        else $display("FAIL %s wr_count: got %0d expected %0d", e.tag, wr_count, e.ec);
      end
    end
  end

  initial begin
    logic [4:0]  r;
    logic [4:0]  a1;
    logic [4:0]  a2;
    int          waited;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;

    cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, "reset");
    for (int i = 0; i < 32; i++)
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 1'b1, "sweep");

    cycle(1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5, 5'd31, 1'b1, "wr_x5");
    cycle(1'b0, 1'b1, 5'd31, 32'h12345678, 5'd5, 5'd31, 1'b1, "wr_x31");
    cycle(1'b0, 1'b0, 5'd0,  32'd0,        5'd5, 5'd31, 1'b1, "rd_x5_x31");

    cycle(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, "x0_wr");
    cycle(1'b0, 1'b0, 5'd0, 32'd0,        5'd0, 5'd0, 1'b1, "x0_after");

    cycle(1'b0, 1'b1, 5'd7, 32'h11111111, 5'd0, 5'd0, 1'b1, "x7_init");
    cycle(1'b0, 1'b1, 5'd7, 32'h22222222, 5'd7, 5'd7, 1'b1, "raw_x7");
    cycle(1'b0, 1'b0, 5'd0, 32'd0,        5'd7, 5'd7, 1'b1, "raw_x7_after");

    cycle(1'b0, 1'b1, 5'd3, 32'hAAAAAAAA, 5'd3, 5'd0, 1'b1, "x3_init");
    cycle(1'b1, 1'b1, 5'd3, 32'h55555555, 5'd3, 5'd3, 1'b1, "clr_collide");
    cycle(1'b0, 1'b0, 5'd0, 32'd0,        5'd3, 5'd7, 1'b1, "clr_after");

    for (int i = 0; i < 400; i++) begin
      r  = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? r : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? r : 5'($urandom_range(0, 31));
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), r, $urandom,
            a1, a2, 1'b1, "random");
    end

    cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, "sat_reset");
    for (int i = 1; i <= 300; i++)
      cycle(1'b0, 1'b1, 5'd1, 32'(i), 5'd1, 5'd2, 1'b1, "sat_wr");
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd1, 1'b1, "sat_final");
    cycle(1'b0, 1'b1, 5'd9, 32'h0BADF00D, 5'd9, 5'd1, 1'b1, "sat_hold");
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0, 1'b1, "sat_hold_rd");

    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    if (q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/banco_registros.md
Name: banco_registros

Overview:
- RISC-V integer register file. 31 writable 32-bit registers plus hardwired-zero x0.
- Sits directly upstream of the pipeline operand registers. Its two read ports feed the rs1/rs2 operand register inputs.
- Its write port consumes the write-back result produced by the downstream stage.
- Storage is edge-triggered. Reads are combinational.

Parameters:
DATA_WIDTH, 32, width of each register and of every data port
ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH = 32

Ports:
clk  input  1  system clock, all state updates on rising edge
clear  input  1  synchronous active-high reset
we  input  1  write enable for write-back port
rd_addr  input  ADDR_WIDTH  destination register index
wd  input  DATA_WIDTH  write-back data
rs1_addr  input  ADDR_WIDTH  read port 1 index
rs2_addr  input  ADDR_WIDTH  read port 2 index
rs1_data  output  DATA_WIDTH  read port 1 data
rs2_data  output  DATA_WIDTH  read port 2 data
wr_count  output  8  number of committed writes since reset, saturating

Behaviour:
- Clock and reset: single clock clk. Reset clear is synchronous and active-high, sampled on rising edge of clk.
- Reset, clear=1 at rising edge:
  - All registers x1..x31 become 0x00000000.
  - wr_count becomes 0.
  - clear has priority over any simultaneous write; the write is discarded.
- Reset values: rs1_data and rs2_data read 0x00000000 for every address after reset. wr_count = 0.
- Write (clear=0, we=1, rd_addr!=0 at rising edge):
  - reg[rd_addr] <= wd.
  - Visible on read ports from the next cycle (one-cycle write latency) unless bypass is enabled.
- Write to x0 (rd_addr=0):
  - Discarded, no state change.
  - Does not increment wr_count.
- we=0: no state change. rd_addr and wd are don't-care.
- Read: rsN_data = reg[rsN_addr], purely combinational, zero-cycle latency.
  - rsN_addr=0 always returns 0x00000000, regardless of any write.
- Both read ports may address the same register simultaneously; both return the same value.
- Simultaneous read and write to the same index, bypass disabled: read returns the old value during that cycle, new value after the edge.
- wr_count:
  - Increments by 1 per committed write (we=1, rd_addr!=0, clear=0).
  - Saturates at 0xFF and does not wrap.
- Reset mid-operation: clear asserted in any cycle takes effect at that edge. The write presented in that cycle is lost; no partial update.
- No X propagation: every register has a defined value after the first clear.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If we=1, clear=0, rd_addr!=0 and rsN_addr==rd_addr, then rsN_data = wd combinationally in the same cycle.
  - Applies to each port independently.
  - x0 is never bypassed.
- Not defined:
  - Reads return stored contents only.
  - Same-cycle read-after-write returns the old value.
  - Storage and wr_count behaviour are identical in both builds.

Test Plan:
- Reset then sweep: clear=1 for one edge, then read all 32 indices on both ports -> every read 0x00000000, wr_count=0.
- Basic write/read: write x5=0xDEADBEEF, then x31=0x12345678 on consecutive cycles -> next cycle rs1_addr=5 gives 0xDEADBEEF, rs2_addr=31 gives 0x12345678, wr_count=2.
- x0 protection: we=1, rd_addr=0, wd=0xFFFFFFFF -> rs1_addr=0 reads 0x00000000 in that cycle and the next, wr_count unchanged.
- Same-cycle RAW on x7 (old value 0x11111111, wd=0x22222222, rs1_addr=rs2_addr=7):
  - Without REGFILE_BYPASS_EN -> both ports read 0x11111111 that cycle, then 0x22222222.
  - With REGFILE_BYPASS_EN -> both ports read 0x22222222 immediately.
- Reset/write collision: x3=0xAAAAAAAA stored; assert clear with we=1, rd_addr=3, wd=0x55555555 -> after edge x3 reads 0x00000000, wr_count=0.
- Counter saturation: 300 consecutive writes to x1 with incrementing data -> wr_count reaches 0xFF and holds; x1 reads 300 (0x0000012C) after the last write.
